// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory sitting on the CPU load/store port. A request is
// captured in IDLE, the pipeline is held for LATENCY cycles, the word access
// is performed on an internal array and a one-cycle acknowledge is returned
// together with the read data and an error flag.
//
// Parameters:
//   LATENCY  cycles from the accept edge to ack_o, ack cycle included (1..15)
//   DEPTH    number of 32-bit words in the array
//
// Ports:
//   clk_i    single clock, rising edge
//   rst_i    asynchronous active-low reset
//   req_i    access request, held by the CPU until it sees ack_o
//   we_i     1 = store, 0 = load (valid with req_i)
//   addr_i   byte address (valid with req_i)
//   wdata_i  store data (valid with req_i)
//   rdata_o  registered load data, held until the next load/error completion
//   ack_o    registered one-cycle completion pulse
//   err_o    registered error qualifier, meaningful only with ack_o
//   stall_o  combinational pipeline hold request
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  // BUSY runs LATENCY-1 cycles, so the countdown starts at LATENCY-2.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_decErr;
  logic            w_busyDone;
  logic            w_directAcc;
  logic            w_accWe;
  logic [AW-1:0]   w_accIdx;
  logic [31:0]     w_accData;
  logic            w_memWrite;

  // Request decode. Accept is gated by reset so a held request cannot touch
  // the array while reset is asserted. With LATENCY=1 a valid access is done
  // straight from the inputs on the accept edge; otherwise the captured
  // registers drive the access at the end of BUSY.
  always_comb begin
    w_accept    = rst_i && (r_state == IDLE) && req_i;
    w_decErr    = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= DEPTH_W);
    w_busyDone  = (r_state == BUSY) && (r_cnt == 4'd0);
    w_directAcc = SINGLE && w_accept && !w_decErr;
    w_accWe     = w_directAcc ? we_i : r_we;
    w_accIdx    = w_directAcc ? addr_i[AW+1:2] : r_idx;
    w_accData   = w_directAcc ? wdata_i : r_wdata;
    w_memWrite  = (w_directAcc || w_busyDone) && w_accWe;
    stall_o     = rst_i && (((r_state == IDLE) && req_i) || (r_state == BUSY));
  end

  // Storage array. Deliberately outside the reset domain so its contents
  // survive a reset; writes only fire from the access points decoded above.
  always_ff @(posedge clk_i) begin
    if (w_memWrite) begin
      r_mem[w_accIdx] <= w_accData;
    end
  end

  // Control FSM with registered response outputs. Errors skip BUSY and
  // complete in the cycle after accept regardless of LATENCY. In ACK the
  // still-high req_i belongs to the completing transaction and is ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      rdata_o <= 32'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[AW+1:2];
            r_wdata <= wdata_i;
            r_cnt   <= CNT_INIT;
            if (w_decErr) begin
              r_state <= ACK;
              ack_o   <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= 32'd0;
            end else if (SINGLE) begin
              r_state <= ACK;
              ack_o   <= 1'b1;
              err_o   <= 1'b0;
              if (!we_i) begin
                rdata_o <= r_mem[w_accIdx];
              end
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ACK;
            ack_o   <= 1'b1;
            err_o   <= 1'b0;
            if (!r_we) begin
              rdata_o <= r_mem[r_idx];
            end
          end
        end
        ACK: begin
          r_state <= IDLE;
          err_o   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Scoreboard bench for data_mem_responder. The main instance uses LATENCY=4,
// DEPTH=32; a second instance uses LATENCY=1. A word-array reference model
// predicts each response, which is queued when the request is issued and
// popped by an independent monitor whenever ack_o is seen.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        req = 1'b0, weI = 1'b0;
  logic [31:0] addrI = 32'd0, wdataI = 32'd0;
  logic [31:0] rdata;
  logic        ack, err, stall;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = 32'd0, wdata1 = 32'd0;
  logic [31:0] rdata1;
  logic        ack1, err1, stall1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          ackCyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [32];
  logic [31:0] lastRdata = 32'd0;

  data_mem_responder #(.LATENCY(LAT), .DEPTH(32)) dut (
    .clk_i(clk), .rst_i(rstN), .req_i(req), .we_i(weI), .addr_i(addrI),
    .wdata_i(wdataI), .rdata_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall)
  );

  data_mem_responder #(.LATENCY(1), .DEPTH(32)) dut1 (
    .clk_i(clk), .rst_i(rstN), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  // Free-running clock and cycle counter used to time acknowledges.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Issue one request, predict its response from the word-array model and
  // hold req until ack is seen. req stays high through the ack edge, which
  // the design must ignore.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit toggle);
    exp_t e;
    int   c;
    bit   seen;
    logic [4:0] idx;
    @(posedge clk); #1;
    req = 1'b1; weI = we; addrI = addr; wdataI = wdata;
    c = cyc;
    idx = addr[6:2];
    e.err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd32);
    e.ackCyc = e.err ? c + 1 : c + LAT;
    if (e.err) begin
      e.rdata = 32'd0;
      lastRdata = 32'd0;
    end else if (we) begin
      model[idx] = wdata;
      e.rdata = lastRdata;
    end else begin
      e.rdata = model[idx];
      lastRdata = e.rdata;
    end
    sbq.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      checkOutput("stall", {31'd0, stall}, {31'd0, (cyc < e.ackCyc)});
      if (ack) begin
        seen = 1'b1;
      end else if (toggle && cyc > c) begin
        addrI = $urandom; wdataI = $urandom; weI = 1'($urandom_range(0, 1));
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("[TB] FAIL ack timeout: no ack for request at cycle %0d", c);
      sbq.delete();
    end
  endtask

  // Drop the request and check nothing further happens.
  task automatic idle(input int n);
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput("idle stall", {31'd0, stall}, 32'd0);
    end
  endtask

  // One access on the LATENCY=1 instance with explicit cycle checks.
  task automatic lat1Access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expRdata);
    @(posedge clk); #1;
    req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    @(negedge clk);
    checkOutput("lat1 stall c0", {31'd0, stall1}, 32'd1);
    checkOutput("lat1 ack c0", {31'd0, ack1}, 32'd0);
    @(negedge clk);
    checkOutput("lat1 ack c1", {31'd0, ack1}, 32'd1);
    checkOutput("lat1 stall c1", {31'd0, stall1}, 32'd0);
    checkOutput("lat1 err", {31'd0, err1}, 32'd0);
    checkOutput("lat1 rdata", rdata1, expRdata);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("lat1 ack c2", {31'd0, ack1}, 32'd0);
    checkOutput("lat1 stall c2", {31'd0, stall1}, 32'd0);
  endtask

  // Monitor: every ack must match the oldest outstanding prediction,
  // including the cycle in which it arrives.
  always @(negedge clk) begin
    exp_t m;
    if (rstN && ack) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL unexpected ack: got ack with empty scoreboard at cycle %0d", cyc);
      end else begin
        m = sbq.pop_front();
        checkOutput("err", {31'd0, err}, {31'd0, m.err});
        checkOutput("rdata", rdata, m.rdata);
        checkOutput("ack cycle", cyc, m.ackCyc);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    #2 rstN = 1'b0;
    #1;
    checkOutput("reset ack", {31'd0, ack}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;

    // Fill every word so later loads have known contents.
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 1'b0);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
    idle(2);

    // Back-to-back store/load with req held through ack.
    applyStimulus(1'b1, 32'h0, 32'h1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    idle(8);

    applyStimulus(1'b0, 32'h13, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h80, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);

    // Inputs scrambled after accept.
    applyStimulus(1'b1, 32'h20, 32'h12345678, 1'b1);
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b1);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom | 32'h80) & 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, 31) * 4);
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset during BUSY of a store: dropped, no ack, outputs cleared at once.
    applyStimulus(1'b1, 32'h8, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
    idle(1);
    @(posedge clk); #1;
    req = 1'b1; weI = 1'b1; addrI = 32'h8; wdataI = 32'h55;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midreset ack", {31'd0, ack}, 32'd0);
    checkOutput("midreset err", {31'd0, err}, 32'd0);
    checkOutput("midreset rdata", rdata, 32'd0);
    checkOutput("midreset stall", {31'd0, stall}, 32'd0);
    req = 1'b0;
    lastRdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    applyStimulus(1'b0, 32'h8, 32'h0, 1'b0);
    idle(2);

    // LATENCY=1 instance.
    lat1Access(1'b1, 32'h4, 32'hA5A5A5A5, 32'h0);
    lat1Access(1'b0, 32'h4, 32'h0, 32'hA5A5A5A5);

    idle(3);
    checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
